// File: rtl/pda_run_ctrl.sv
// pda_run_ctrl: run/halt controller for the PDA pipeline.
// Drives the core's halt input, counts un-halted cycles and stops on a
// cycle limit, an instruction-header breakpoint, an abort or counter
// saturation. It also supports single-stepping.
module pda_run_ctrl #(
  parameter int CNT_W  = 17,
  parameter int HDR_W  = 32,
  parameter int NUM_BP = 2,
  parameter int BP_IW  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    start,
  input  logic                    step,
  input  logic                    abort,
  input  logic                    clear,
  input  logic [CNT_W-1:0]        limit,
  input  logic [NUM_BP-1:0]       bp_en,
  input  logic [NUM_BP*HDR_W-1:0] bp_value,
  input  logic [HDR_W-1:0]        inst_head,
  input  logic                    inst_valid,
  output logic                    halt,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [1:0]              state,
  output logic [2:0]              halt_cause,
  output logic [BP_IW-1:0]        bp_hit,
  output logic                    done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LIMIT    = 3'd1,
    CAUSE_BP       = 3'd2,
    CAUSE_ABORT    = 3'd3,
    CAUSE_STEP     = 3'd4,
    CAUSE_OVERFLOW = 3'd5
  } cause_t;

  localparam logic [1:0] MODE_RUN_N = 2'd1;

  state_t           r_state;
  cause_t           r_cause;
  logic [CNT_W-1:0] r_count;
  logic [BP_IW-1:0] r_bp_hit;
  logic             r_halt;
  logic             r_done;

  state_t           w_state_nxt;
  cause_t           w_cause_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [BP_IW-1:0] w_bp_hit_nxt;
  logic             w_done_nxt;

  // The increment is computed one bit wider so that a saturated counter is
  // recognised instead of wrapping back to zero.
  logic [CNT_W:0]   w_count_p1;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_ovf;
  logic             w_limit_hit;
  logic             w_bp_match;
  logic [BP_IW-1:0] w_bp_idx;

  assign w_count_p1  = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
  assign w_count_inc = w_count_p1[CNT_W] ? r_count : w_count_p1[CNT_W-1:0];
  assign w_ovf       = (w_count_p1 >= {1'b0, {CNT_W{1'b1}}});
  assign w_limit_hit = (mode == MODE_RUN_N) && (w_count_p1 >= {1'b0, limit});

  // Breakpoint comparators; scanning from the top lets the lowest index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_bp_match = 1'b0;
    w_bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (inst_valid && bp_en[i] && (inst_head == bp_value[i*HDR_W +: HDR_W])) begin
        w_bp_match = 1'b1;
        w_bp_idx   = BP_IW'(i);
      end
    end
  end

  // Next-state, counter and cause decode; clear overrides every other command.
  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    w_count_nxt  = r_count;
    w_bp_hit_nxt = r_bp_hit;
    w_done_nxt   = 1'b0;

    if (clear) begin
      w_state_nxt  = ST_IDLE;
      w_cause_nxt  = CAUSE_NONE;
      w_count_nxt  = '0;
      w_bp_hit_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_count_nxt = '0;
            if ((mode == MODE_RUN_N) && (limit == '0)) begin
              // A zero limit stops without ever releasing the pipeline.
              w_state_nxt = ST_STOPPED;
              w_cause_nxt = CAUSE_LIMIT;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
              w_cause_nxt = CAUSE_NONE;
            end
          end else if (step) begin
            w_state_nxt = ST_STEP;
          end
        end

        ST_RUN: begin
          w_count_nxt = w_count_inc;
          if (abort || w_bp_match || w_limit_hit || w_ovf) begin
            w_state_nxt = ST_STOPPED;
            w_done_nxt  = 1'b1;
            if (abort) begin
              w_cause_nxt = CAUSE_ABORT;
            end else if (w_bp_match) begin
              w_cause_nxt  = CAUSE_BP;
              w_bp_hit_nxt = w_bp_idx;
            end else if (w_limit_hit) begin
              w_cause_nxt = CAUSE_LIMIT;
            end else begin
              w_cause_nxt = CAUSE_OVERFLOW;
            end
          end
        end

        ST_STEP: begin
          w_count_nxt = w_count_inc;
          w_state_nxt = ST_STOPPED;
          w_done_nxt  = 1'b1;
          if (abort) begin
            w_cause_nxt = CAUSE_ABORT;
          end else if (w_bp_match) begin
            w_cause_nxt  = CAUSE_BP;
            w_bp_hit_nxt = w_bp_idx;
          end else if (w_ovf) begin
            w_cause_nxt = CAUSE_OVERFLOW;
          end else begin
            w_cause_nxt = CAUSE_STEP;
          end
        end

        ST_STOPPED: begin
          // abort has no effect here; the count is kept on resume.
          if (start) begin
            w_state_nxt = ST_RUN;
            w_cause_nxt = CAUSE_NONE;
          end else if (step) begin
            w_state_nxt = ST_STEP;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counter and registered outputs; halt is decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cause  <= CAUSE_NONE;
      r_count  <= '0;
      r_bp_hit <= '0;
      r_halt   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_cause  <= w_cause_nxt;
      r_count  <= w_count_nxt;
      r_bp_hit <= w_bp_hit_nxt;
      r_halt   <= !((w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP));
      r_done   <= w_done_nxt;
    end
  end

  assign halt        = r_halt;
  assign cycle_count = r_count;
  assign state       = r_state;
  assign halt_cause  = r_cause;
  assign bp_hit      = r_bp_hit;
  assign done        = r_done;

endmodule
